// File: rtl/sm_data_mem.sv
// Byte-addressed data memory for the schoolMIPS core with req/ack handshake,
// programmable wait states and byte/half/word access with fault flagging.
//
// state | meaning
// IDLE  | ready for a new request; inputs captured on req
// BUSY  | counting down wait states; access committed when cnt reaches 0
// RESP  | ack pulse; err/rdata valid
module sm_data_mem #(
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              signExt,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              ack,
    output logic              err,
    output logic [31:0]       rdata,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [31:0]       dbgData
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t      state;
    logic [3:0]  cnt;
    logic        regWe;
    logic        regSignExt;
    logic [1:0]  regSize;
    logic [31:0] regAddr;
    logic [31:0] regWdata;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] wordIdx;
    logic [4:0]        laneShift;
    logic              fault;
    logic              commit;
    logic [31:0]       curWord;
    logic [31:0]       laneWord;
    logic [31:0]       loadData;
    logic [31:0]       storeData;
    logic [31:0]       storeMask;
    logic [31:0]       mergedWord;

    always_comb begin
        wordIdx   = regAddr[ADDR_W+1:2];
        laneShift = {regAddr[1:0], 3'b000};
        curWord   = mem[wordIdx];
        laneWord  = curWord >> laneShift;

        fault = (regSize == 2'b11)
             || ((regSize == 2'b01) && regAddr[0])
             || ((regSize == 2'b10) && (regAddr[1:0] != 2'b00))
             || ((regAddr >> (ADDR_W + 2)) != 32'd0);

        case (regSize)
            2'b00: begin
                loadData  = regSignExt ? {{24{laneWord[7]}}, laneWord[7:0]}
                                       : {24'd0, laneWord[7:0]};
                storeMask = 32'h0000_00FF << laneShift;
                storeData = {24'd0, regWdata[7:0]} << laneShift;
            end
            2'b01: begin
                loadData  = regSignExt ? {{16{laneWord[15]}}, laneWord[15:0]}
                                       : {16'd0, laneWord[15:0]};
                storeMask = 32'h0000_FFFF << laneShift;
                storeData = {16'd0, regWdata[15:0]} << laneShift;
            end
            default: begin
                loadData  = curWord;
                storeMask = 32'hFFFF_FFFF;
                storeData = regWdata;
            end
        endcase

        // Read-modify-write keeps the lanes outside the access untouched
        mergedWord = (curWord & ~storeMask) | (storeData & storeMask);
    end

    assign commit  = (state == BUSY) && (cnt == 4'd0);
    assign ready   = (state == IDLE);
    assign ack     = (state == RESP);
    assign dbgData = mem[dbgAddr];

    // Reset has priority over a store that commits on the same edge
    always_ff @(posedge clk) begin
        if (!rst && commit && regWe && !fault)
            mem[wordIdx] <= mergedWord;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            err        <= 1'b0;
            rdata      <= 32'd0;
            regWe      <= 1'b0;
            regSignExt <= 1'b0;
            regSize    <= 2'b00;
            regAddr    <= 32'd0;
            regWdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        regWe      <= we;
                        regSize    <= size;
                        regSignExt <= signExt;
                        regAddr    <= addr;
                        regWdata   <= wdata;
                        cnt        <= 4'(WAIT_CYCLES);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err   <= fault;
                        rdata <= (fault || regWe) ? 32'd0 : loadData;
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_data_mem.sv
// Scoreboard bench for sm_data_mem: one instance with no wait states and one
// with three, each with its own expectation queue and ack monitor.
module tb_sm_data_mem;
    logic clk;
    int   nCyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          ackCyc;
        int          id;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   nextId = 0;

    logic        rst0, req0, we0, se0, ready0, ack0, err0;
    logic [1:0]  size0;
    logic [31:0] addr0, wdata0, rdata0, dbgData0;
    logic [6:0]  dbgAddr0;

    logic        rst3, req3, we3, se3, ready3, ack3, err3;
    logic [1:0]  size3;
    logic [31:0] addr3, wdata3, rdata3, dbgData3;
    logic [6:0]  dbgAddr3;

    sm_data_mem #(.ADDR_W(7), .WAIT_CYCLES(0)) d0 (
        .clk(clk), .rst(rst0), .req(req0), .we(we0), .size(size0), .signExt(se0),
        .addr(addr0), .wdata(wdata0), .ready(ready0), .ack(ack0), .err(err0),
        .rdata(rdata0), .dbgAddr(dbgAddr0), .dbgData(dbgData0)
    );

    sm_data_mem #(.ADDR_W(7), .WAIT_CYCLES(3)) d3 (
        .clk(clk), .rst(rst3), .req(req3), .we(we3), .size(size3), .signExt(se3),
        .addr(addr3), .wdata(wdata3), .ready(ready3), .ack(ack3), .err(err3),
        .rdata(rdata3), .dbgAddr(dbgAddr3), .dbgData(dbgData3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) nCyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (ack0) begin
            exp_t e;
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0 unexpected ack at cycle %0d", nCyc);
            end else begin
                e = q0.pop_front();
                chk($sformatf("dut0 #%0d err", e.id), {31'd0, err0}, {31'd0, e.err});
                chk($sformatf("dut0 #%0d rdata", e.id), rdata0, e.rdata);
                chk($sformatf("dut0 #%0d ack cycle", e.id), 32'(nCyc), 32'(e.ackCyc));
            end
        end
    end

    always @(negedge clk) begin
        if (ack3) begin
            exp_t e;
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut3 unexpected ack at cycle %0d", nCyc);
            end else begin
                e = q3.pop_front();
                chk($sformatf("dut3 #%0d err", e.id), {31'd0, err3}, {31'd0, e.err});
                chk($sformatf("dut3 #%0d rdata", e.id), rdata3, e.rdata);
                chk($sformatf("dut3 #%0d ack cycle", e.id), 32'(nCyc), 32'(e.ackCyc));
            end
        end
    end

    task automatic waitReady(input int sel);
        int k;
        k = 0;
        @(negedge clk);
        while (!(sel == 0 ? ready0 : ready3) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            total++;
            bad++;
            $display("FAIL dut%0d timeout waiting for ready", sel == 0 ? 0 : 3);
        end
    endtask

    task automatic waitIdle(input int sel);
        int k;
        k = 0;
        @(negedge clk);
        while (!((sel == 0) ? (ready0 && q0.size() == 0) : (ready3 && q3.size() == 0)) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            total++;
            bad++;
            $display("FAIL dut%0d timeout waiting for idle", sel == 0 ? 0 : 3);
        end
    endtask

    // Drive one access at a negedge where ready is high; acceptance is the next posedge.
    task automatic issue(input int sel, input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic expErr, input logic [31:0] expData);
        exp_t e;
        waitReady(sel);
        e.err   = expErr;
        e.rdata = expData;
        e.id    = nextId++;
        if (sel == 0) begin
            we0 = wr; size0 = sz; se0 = sx; addr0 = a; wdata0 = wd; req0 = 1'b1;
            e.ackCyc = nCyc + 2;
            q0.push_back(e);
        end else begin
            we3 = wr; size3 = sz; se3 = sx; addr3 = a; wdata3 = wd; req3 = 1'b1;
            e.ackCyc = nCyc + 5;
            q3.push_back(e);
        end
        @(negedge clk);
        if (sel == 0) req0 = 1'b0;
        else          req3 = 1'b0;
    endtask

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    initial begin
        int   n;
        exp_t e;
        rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; size0 = W; se0 = 1'b0;
        addr0 = 32'd0; wdata0 = 32'd0; dbgAddr0 = 7'd0;
        rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; size3 = W; se3 = 1'b0;
        addr3 = 32'd0; wdata3 = 32'd0; dbgAddr3 = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready0", {31'd0, ready0}, 32'd1);
        chk("reset ack0",   {31'd0, ack0},   32'd0);
        chk("reset err0",   {31'd0, err0},   32'd0);
        chk("reset rdata0", rdata0,          32'd0);
        chk("reset ready3", {31'd0, ready3}, 32'd1);
        chk("reset ack3",   {31'd0, ack3},   32'd0);
        chk("reset rdata3", rdata3,          32'd0);
        rst0 = 1'b0;
        rst3 = 1'b0;

        // No wait states: word store/load and sub-word loads
        issue(0, 1, W, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0);
        issue(0, 0, W, 0, 32'h10, 32'h0,         0, 32'hDEAD_BEEF);
        issue(0, 0, B, 1, 32'h13, 32'h0,         0, 32'hFFFF_FFDE);
        issue(0, 0, B, 0, 32'h12, 32'h0,         0, 32'h0000_00AD);
        issue(0, 0, H, 1, 32'h12, 32'h0,         0, 32'hFFFF_DEAD);
        issue(0, 0, H, 0, 32'h10, 32'h0,         0, 32'h0000_BEEF);
        issue(0, 0, B, 1, 32'h10, 32'h0,         0, 32'hFFFF_FFEF);
        issue(0, 0, H, 1, 32'h10, 32'h0,         0, 32'hFFFF_BEEF);
        issue(0, 0, B, 1, 32'h11, 32'h0,         0, 32'hFFFF_FFBE);

        // Partial stores into a zeroed word
        issue(0, 1, W, 0, 32'h20, 32'h0,         0, 32'h0);
        issue(0, 1, B, 0, 32'h21, 32'h1234_56AB, 0, 32'h0);
        issue(0, 1, H, 0, 32'h22, 32'h0000_CAFE, 0, 32'h0);
        issue(0, 1, W, 0, 32'h00, 32'h0102_0304, 0, 32'h0);
        waitIdle(0);
        dbgAddr0 = 7'd8;
        #1 chk("dbg word 8 after SB/SH", dbgData0, 32'hCAFE_AB00);
        dbgAddr0 = 7'd0;
        #1 chk("dbg word 0", dbgData0, 32'h0102_0304);

        // Faults: no write, err set, rdata cleared even after a nonzero load
        issue(0, 0, B, 0, 32'h21, 32'h0,         0, 32'h0000_00AB);
        issue(0, 1, H, 0, 32'h21, 32'hFFFF_FFFF, 1, 32'h0);
        issue(0, 0, W, 0, 32'h10, 32'h0,         0, 32'hDEAD_BEEF);
        issue(0, 0, W, 0, 32'h22, 32'h0,         1, 32'h0);
        issue(0, 1, X, 0, 32'h20, 32'hFFFF_FFFF, 1, 32'h0);
        issue(0, 0, X, 0, 32'h20, 32'h0,         1, 32'h0);
        issue(0, 1, W, 0, 32'h200, 32'h7777_7777, 1, 32'h0);
        issue(0, 0, W, 0, 32'h200, 32'h0,        1, 32'h0);
        issue(0, 0, H, 0, 32'h81, 32'h0,         1, 32'h0);
        waitIdle(0);
        dbgAddr0 = 7'd8;
        #1 chk("dbg word 8 after faults", dbgData0, 32'hCAFE_AB00);
        dbgAddr0 = 7'd0;
        #1 chk("dbg word 0 after oob store", dbgData0, 32'h0102_0304);

        // Three wait states: prepare data
        issue(1, 1, W, 0, 32'h40, 32'h1122_3344, 0, 32'h0);
        issue(1, 1, W, 0, 32'h44, 32'hA5A5_5A5A, 0, 32'h0);
        issue(1, 1, W, 0, 32'h10, 32'h0,         0, 32'h0);
        waitIdle(1);

        // req held high across two loads; inputs disturbed while BUSY
        waitReady(1);
        n = nCyc;
        we3 = 1'b0; size3 = W; se3 = 1'b0; addr3 = 32'h40; wdata3 = 32'h0; req3 = 1'b1;
        e.err = 1'b0; e.rdata = 32'h1122_3344; e.ackCyc = n + 5; e.id = nextId++;
        q3.push_back(e);
        @(negedge clk);
        addr3 = 32'h44; we3 = 1'b1; size3 = X; wdata3 = 32'hFFFF_FFFF;
        e.err = 1'b0; e.rdata = 32'hA5A5_5A5A; e.ackCyc = n + 11; e.id = nextId++;
        q3.push_back(e);
        repeat (2) @(negedge clk);
        we3 = 1'b0; size3 = W;
        repeat (4) @(negedge clk);
        chk("held second accepted", {31'd0, ready3}, 32'd0);
        req3 = 1'b0; we3 = 1'b1; size3 = X; addr3 = 32'h11;
        waitIdle(1);
        dbgAddr3 = 7'd17;
        #1 chk("dbg word 0x44 unchanged", dbgData3, 32'hA5A5_5A5A);

        // Reset coinciding with the commit edge of a store
        waitReady(1);
        n = nCyc;
        we3 = 1'b1; size3 = W; se3 = 1'b0; addr3 = 32'h10; wdata3 = 32'h55AA_55AA; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset test cycle alignment", 32'(nCyc), 32'(n + 4));
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        dbgAddr3 = 7'd4;
        #1;
        chk("post-reset ready3", {31'd0, ready3}, 32'd1);
        chk("post-reset ack3",   {31'd0, ack3},   32'd0);
        chk("post-reset rdata3", rdata3,          32'd0);
        chk("post-reset err3",   {31'd0, err3},   32'd0);
        chk("word 4 not written", dbgData3,       32'd0);
        repeat (6) @(negedge clk);
        issue(1, 0, W, 0, 32'h10, 32'h0, 0, 32'h0);
        issue(1, 0, B, 0, 32'h43, 32'h0, 0, 32'h0000_0011);
        waitIdle(1);

        chk("dut0 queue drained", 32'(q0.size()), 32'd0);
        chk("dut3 queue drained", 32'(q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", nCyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sm_data_mem.md
# sm_data_mem

Byte-addressed, parametrised data memory for the schoolMIPS core with a request/acknowledge handshake and programmable wait states. It supports byte, halfword and word loads and stores, with sign or zero extension on loads, and flags misaligned, out-of-range or illegal-size accesses. It sits between the CPU datapath and the register-file write-back mux, and replaces the single-cycle combinational halfword store.

## Interface
Parameters:
- ADDR_W, 7: word-address width; depth = 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1: extra busy cycles per access, legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  access request
- we  in  1  1 = store, 0 = load; sampled with req
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- signExt  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address, little-endian
- wdata  in  32  store data; low byte/half/word used according to size
- ready  out  1  block idle, request can be accepted
- ack  out  1  one-cycle completion pulse
- err  out  1  access faulted; valid only while ack=1
- rdata  out  32  load result; valid while ack=1
- dbgAddr  in  ADDR_W  debug word index
- dbgData  out  32  combinational read of mem[dbgAddr]

## Operation
- FSM states IDLE, BUSY, RESP. Output ready = (state==IDLE). Output ack = (state==RESP).
- IDLE:
  - On req&ready, capture we, size, signExt, addr and wdata into registers.
  - Load cnt=WAIT_CYCLES and go to BUSY.
  - Input changes after acceptance have no effect.
- BUSY:
  - If cnt≠0, decrement cnt.
  - If cnt==0, perform the access and go to RESP.
- RESP: go to IDLE. req is ignored in BUSY and RESP; requests are not queued.
- Fault check (err=1) if any of:
  - size==11
  - size==01 with addr[0]=1
  - size==10 with addr[1:0]≠0
  - addr[31:ADDR_W+2]≠0
- On a fault: no memory write, rdata=0, err=1 during ack.
- Word index = addr[ADDR_W+1:2].
- Byte lane = addr[1:0] (lane 0 = bits 7:0). Half lane = addr[1].
- Load: select the lane, then extend to 32 bits with signExt; word loads are unextended. rdata is registered on the BUSY→RESP edge and holds until the next completed access.
- Store: byte-enabled read-modify-write of the addressed lanes only. Other lanes are unchanged. rdata=0 for stores.
- Memory contents are not reset or initialised.

## Timing
- Acceptance edge E0 (req&ready sampled high).
- State is BUSY for WAIT_CYCLES+1 cycles. Commit and rdata capture happen at edge E0+WAIT_CYCLES+1.
- ack/err/rdata are valid in the cycle after the commit edge, i.e. WAIT_CYCLES+1 cycles after acceptance.
- ready returns high one cycle after ack. Peak throughput is one access per WAIT_CYCLES+3 cycles.
- A store is visible on dbgData and to any later request from the cycle after its commit edge. Read-after-write to the same word returns the new data.
- Reset values after a clock edge with rst=1: state IDLE, ready=1, ack=0, err=0, rdata=0, cnt=0.
- rst during BUSY:
  - The access is aborted. No ack is generated.
  - A store whose commit edge coincides with rst=1 is not written; rst has priority.
- req held high continuously: a new access is accepted each time ready is high. No double acceptance within one access.

## Test plan
- WAIT_CYCLES=0:
  - Stimulus: SW addr=0x10, wdata=0xDEADBEEF. Then LW addr=0x10.
  - Required: each ack 1 cycle after acceptance; load rdata=0xDEADBEEF, err=0.
- Byte and half loads on word 0x10 holding 0xDEADBEEF:
  - LB addr=0x13, signExt=1 → 0xFFFFFFDE.
  - LBU addr=0x12 → 0x000000AD.
  - LH addr=0x12, signExt=1 → 0xFFFFDEAD.
  - LHU addr=0x10 → 0x0000BEEF.
- Stores into zeroed word 0x20:
  - SB addr=0x21, wdata=0x123456AB. Then SH addr=0x22, wdata=0x0000CAFE.
  - Required: dbgData at index 8 = 0xCAFEAB00.
- Faults, each with no memory write, err=1, rdata=0:
  - SH at addr 0x21
  - LW at addr 0x22
  - size=11
  - addr=0x200 with ADDR_W=7
- WAIT_CYCLES=3:
  - Stimulus: req held high across two loads.
  - Required: ack exactly 4 cycles after each acceptance; the second acceptance occurs 1 cycle after the first ack; inputs changed during BUSY do not alter the result.
- Reset:
  - Stimulus: SW of 0x55AA55AA to word 4, previously 0, with rst pulsed on the commit edge.
  - Required: no ack; word 4 remains 0; ready=1 and rdata=0 after reset.
